// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Holds the fetch FSM state type, the PC and instruction widths, and the
// default reset fetch address used by fetch_unit and pc_reg.
package cpu_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 30'h0000_0000;

  typedef enum logic [1:0] {
    RESET   = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with its next-value mux and incrementer.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_load           : update the PC this cycle (decode handshake)
//   i_mux_pc_src     : 1 = load i_pc30, 0 = load pc+1
//   i_pc30           : branch/jump target word address
//   o_pc             : current PC (word address)
//   o_incr_pc        : current PC + 1, wrapping at 30 bits
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_mux_pc_src,
  input  logic [PC_W-1:0] i_pc30,
  output logic [PC_W-1:0] o_pc,
  output logic [PC_W-1:0] o_incr_pc
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_incr;
  logic [PC_W-1:0] w_pc_next;

  // Natural 30-bit wrap: 3FFF_FFFF + 1 -> 0 with no carry out.
  assign w_incr = r_pc + PC_ONE;

  // The select and target only matter on a load cycle; otherwise the PC holds.
  always_comb begin
    w_pc_next = r_pc;
    if (i_load) begin
      w_pc_next = i_mux_pc_src ? i_pc30 : w_incr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc      = r_pc;
  assign o_incr_pc = w_incr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word from instruction memory, holds
// the returned instruction for decode, and advances the PC on acceptance.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_mux_pc_src     : 1 = next PC is i_pc30, 0 = sequential (sampled on handshake)
//   i_pc30           : branch/jump target word address
//   o_incr_pc        : presented PC + 1, to the next-PC stage
//   o_imem_req       : instruction memory read request
//   o_imem_addr      : request word address
//   i_imem_ack       : memory returns i_imem_data this cycle
//   i_imem_data      : returned instruction word
//   o_instr          : instruction presented to decode
//   o_instr_valid    : o_instr / o_incr_pc are valid
//   i_instr_ready    : decode accepts the instruction this cycle
//   o_fetch_cnt      : number of accepted instructions (wraps)
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_mux_pc_src,
  input  logic [PC_W-1:0]    i_pc30,
  output logic [PC_W-1:0]    o_incr_pc,
  output logic               o_imem_req,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic [CNT_W-1:0]   o_fetch_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [INSTR_W-1:0] r_instr;
  logic [CNT_W-1:0]   r_fetch_cnt;
  logic               w_capture;
  logic               w_handshake;
  logic [PC_W-1:0]    w_pc;

  // State register. Reset forces RESET asynchronously, so a request in
  // flight is dropped immediately and any later ack lands outside FETCH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Moore outputs. Ack is only honoured in FETCH and ready
  // only in PRESENT, which gives the "ignored elsewhere" behaviour for free.
  always_comb begin
    w_state_next  = r_state;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    w_capture     = 1'b0;
    w_handshake   = 1'b0;
    case (r_state)
      RESET: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_capture    = 1'b1;
          w_state_next = PRESENT;
        end
      end
      PRESENT: begin
        o_instr_valid = 1'b1;
        if (i_instr_ready) begin
          w_handshake  = 1'b1;
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = RESET;
      end
    endcase
  end

  // Instruction buffer: loaded only on an accepted memory response, held
  // through PRESENT until decode takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= '0;
    end else if (w_capture) begin
      r_instr <= i_imem_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt <= '0;
    end else if (w_handshake) begin
      r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (w_handshake),
    .i_mux_pc_src (i_mux_pc_src),
    .i_pc30       (i_pc30),
    .o_pc         (w_pc),
    .o_incr_pc    (o_incr_pc)
  );

  assign o_imem_addr = w_pc;
  assign o_instr     = r_instr;
  assign o_fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Two instances share all inputs: one
// with the default reset PC and one with RESET_PC = 30'h3FFF_FFFF.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mux;
  logic [29:0] pc30;
  logic        ack;
  logic [31:0] data;
  logic        ready;

  logic [29:0] a_incr, a_addr, w_incr, w_addr;
  logic        a_req, a_valid, w_req, w_valid;
  logic [31:0] a_instr, a_cnt, w_instr, w_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mux_pc_src(mux), .i_pc30(pc30),
    .o_incr_pc(a_incr), .o_imem_req(a_req), .o_imem_addr(a_addr),
    .i_imem_ack(ack), .i_imem_data(data), .o_instr(a_instr),
    .o_instr_valid(a_valid), .i_instr_ready(ready), .o_fetch_cnt(a_cnt)
  );

  fetch_unit #(.RESET_PC(30'h3FFF_FFFF)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_mux_pc_src(mux), .i_pc30(pc30),
    .o_incr_pc(w_incr), .o_imem_req(w_req), .o_imem_addr(w_addr),
    .i_imem_ack(ack), .i_imem_data(data), .o_instr(w_instr),
    .o_instr_valid(w_valid), .i_instr_ready(ready), .o_fetch_cnt(w_cnt)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; ack = 1'b0; ready = 1'b0; mux = 1'b0; pc30 = '0; data = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", a_req); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", a_valid); end
    checks++; if (a_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", a_instr); end
    checks++; if (a_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0", a_cnt); end
    checks++; if (a_addr !== 30'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", a_addr); end
    checks++; if (a_incr !== 30'h1) begin errors++; $display("FAIL rst_incr: got %h want 1", a_incr); end
    checks++; if (w_addr !== 30'h3FFF_FFFF) begin errors++; $display("FAIL rst_wrap_addr: got %h want 3fffffff", w_addr); end
    checks++; if (w_incr !== 30'h0) begin errors++; $display("FAIL rst_wrap_incr: got %h want 0", w_incr); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_req !== 1'b1) begin errors++; $display("FAIL rel_req: got %b want 1", a_req); end
    checks++; if (a_addr !== 30'h0) begin errors++; $display("FAIL rel_addr: got %h want 0", a_addr); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ack = 1'b1; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (a_req !== 1'b1) begin errors++; $display("FAIL b2b_req[%0d]: got %b want 1", k, a_req); end
      checks++; if (a_addr !== 30'(k)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", k, a_addr, 30'(k)); end
      checks++; if (a_cnt !== 32'(k)) begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", k, a_cnt, k); end
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_fvalid[%0d]: got %b want 0", k, a_valid); end
      data = 32'hC000_0000 | 32'(k);
      @(negedge clk);
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, a_valid); end
      checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL b2b_preq[%0d]: got %b want 0", k, a_req); end
      checks++; if (a_instr !== (32'hC000_0000 | 32'(k))) begin errors++; $display("FAIL b2b_instr[%0d]: got %h want %h", k, a_instr, 32'hC000_0000 | 32'(k)); end
      checks++; if (a_incr !== 30'(k + 1)) begin errors++; $display("FAIL b2b_incr[%0d]: got %h want %h", k, a_incr, 30'(k + 1)); end
    end
    ack = 1'b0; ready = 1'b0;
  endtask

  task automatic test_ack_delay();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (a_req !== 1'b1 || a_addr !== 30'h0) begin errors++; $display("FAIL dly_req[%0d]: got req=%b addr=%h want req=1 addr=0", i, a_req, a_addr); end
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL dly_valid[%0d]: got %b want 0", i, a_valid); end
      if (i == 3) begin ack = 1'b1; data = 32'h2001_0005; end
    end
    @(negedge clk);
    ack = 1'b0; data = '0;
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL dly_pvalid: got %b want 1", a_valid); end
    checks++; if (a_instr !== 32'h2001_0005) begin errors++; $display("FAIL dly_instr: got %h want 20010005", a_instr); end
    checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL dly_preq: got %b want 0", a_req); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (a_valid !== 1'b1 || a_req !== 1'b0) begin errors++; $display("FAIL stall_ctl[%0d]: got valid=%b req=%b want 1/0", i, a_valid, a_req); end
      checks++; if (a_instr !== 32'h2001_0005) begin errors++; $display("FAIL stall_instr[%0d]: got %h want 20010005", i, a_instr); end
      checks++; if (a_incr !== 30'h1 || a_cnt !== 32'h0) begin errors++; $display("FAIL stall_pc[%0d]: got incr=%h cnt=%0d want 1/0", i, a_incr, a_cnt); end
      // Stray ack and branch select while not handshaking must be ignored.
      ack = 1'b1; data = 32'hBAD0_0000 | 32'(i); mux = 1'b1; pc30 = 30'h333;
    end
    @(negedge clk);
    checks++; if (a_instr !== 32'h2001_0005) begin errors++; $display("FAIL stall_hold: got %h want 20010005", a_instr); end
    ack = 1'b0; mux = 1'b0; pc30 = '0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (a_addr !== 30'h1 || a_req !== 1'b1) begin errors++; $display("FAIL stall_next: got addr=%h req=%b want 1/1", a_addr, a_req); end
    checks++; if (a_cnt !== 32'h1) begin errors++; $display("FAIL stall_cnt: got %0d want 1", a_cnt); end
  endtask

  task automatic test_branch();
    ack = 1'b1; data = 32'h1111_0001;
    @(negedge clk);
    ack = 1'b0; ready = 1'b1; mux = 1'b1; pc30 = 30'h10;
    @(negedge clk);
    checks++; if (a_addr !== 30'h10 || a_incr !== 30'h11) begin errors++; $display("FAIL br1_addr: got addr=%h incr=%h want 10/11", a_addr, a_incr); end
    ready = 1'b0; mux = 1'b0; ack = 1'b1; data = 32'h1111_0010;
    @(negedge clk);
    ack = 1'b0; mux = 1'b1; pc30 = 30'h333;
    @(negedge clk);
    checks++; if (a_valid !== 1'b1 || a_incr !== 30'h11) begin errors++; $display("FAIL br_toggle: got valid=%b incr=%h want 1/11", a_valid, a_incr); end
    mux = 1'b1; pc30 = 30'h40; ready = 1'b1;
    @(negedge clk);
    checks++; if (a_addr !== 30'h40) begin errors++; $display("FAIL br2_addr: got %h want 40", a_addr); end
    checks++; if (a_cnt !== 32'h3) begin errors++; $display("FAIL br2_cnt: got %0d want 3", a_cnt); end
    ready = 1'b0; mux = 1'b1; pc30 = 30'h99;
    @(negedge clk);
    checks++; if (a_addr !== 30'h40 || a_req !== 1'b1) begin errors++; $display("FAIL br_fetch_toggle: got addr=%h req=%b want 40/1", a_addr, a_req); end
    mux = 1'b0; ack = 1'b1; data = 32'h1111_0040;
    @(negedge clk);
    ack = 1'b0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (a_addr !== 30'h41) begin errors++; $display("FAIL br_seq: got %h want 41", a_addr); end
  endtask

  task automatic test_wrap();
    apply_reset();
    @(negedge clk);
    checks++; if (w_addr !== 30'h3FFF_FFFF || w_req !== 1'b1) begin errors++; $display("FAIL wrap_addr: got addr=%h req=%b want 3fffffff/1", w_addr, w_req); end
    checks++; if (w_incr !== 30'h0) begin errors++; $display("FAIL wrap_incr: got %h want 0", w_incr); end
    ack = 1'b1; data = 32'h0F0F_0F0F;
    @(negedge clk);
    checks++; if (w_valid !== 1'b1 || w_instr !== 32'h0F0F_0F0F || w_incr !== 30'h0) begin errors++; $display("FAIL wrap_present: got valid=%b instr=%h incr=%h", w_valid, w_instr, w_incr); end
    ack = 1'b0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (w_addr !== 30'h0 || w_incr !== 30'h1) begin errors++; $display("FAIL wrap_next: got addr=%h incr=%h want 0/1", w_addr, w_incr); end
    checks++; if (w_cnt !== 32'h1) begin errors++; $display("FAIL wrap_cnt: got %0d want 1", w_cnt); end
  endtask

  task automatic test_reset_mid_fetch();
    // Main instance is in FETCH at address 1 with no ack yet.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_req !== 1'b0 || a_addr !== 30'h0) begin errors++; $display("FAIL midrst_async: got req=%b addr=%h want 0/0", a_req, a_addr); end
    checks++; if (w_req !== 1'b0 || w_addr !== 30'h3FFF_FFFF) begin errors++; $display("FAIL midrst_wrap: got req=%b addr=%h", w_req, w_addr); end
    @(negedge clk);
    rst_n = 1'b1; ack = 1'b1; data = 32'hDEAD_BEEF;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (a_req !== 1'b1 || a_addr !== 30'h0) begin errors++; $display("FAIL stale_req: got req=%b addr=%h want 1/0", a_req, a_addr); end
    checks++; if (a_valid !== 1'b0 || a_instr !== 32'h0) begin errors++; $display("FAIL stale_capture: got valid=%b instr=%h want 0/0", a_valid, a_instr); end
    @(negedge clk);
    checks++; if (a_req !== 1'b1 || a_valid !== 1'b0) begin errors++; $display("FAIL stale_wait: got req=%b valid=%b want 1/0", a_req, a_valid); end
  endtask

  task automatic test_reset_present();
    ack = 1'b1; data = 32'h5555_AAAA;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (a_valid !== 1'b1 || a_instr !== 32'h5555_AAAA) begin errors++; $display("FAIL rp_present: got valid=%b instr=%h", a_valid, a_instr); end
    ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_valid !== 1'b0 || a_instr !== 32'h0 || a_cnt !== 32'h0) begin errors++; $display("FAIL rp_discard: got valid=%b instr=%h cnt=%0d want 0/0/0", a_valid, a_instr, a_cnt); end
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b0;
    @(negedge clk);
    checks++; if (a_addr !== 30'h0 || a_cnt !== 32'h0 || a_req !== 1'b1) begin errors++; $display("FAIL rp_after: got addr=%h cnt=%0d req=%b want 0/0/1", a_addr, a_cnt, a_req); end
  endtask

  initial begin
    rst_n = 1'b0; mux = 1'b0; pc30 = '0; ack = 1'b0; data = '0; ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_ack_delay();
    test_stall();
    test_branch();
    test_wrap();
    test_reset_mid_fetch();
    test_reset_present();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
